// File: rtl/replay_ctrl.sv
// Transmit-side replay buffer controller: numbers outgoing words, mirrors them
// into an external 2^AW-entry RAM, purges on ACK and retransmits on NAK.
module replay_ctrl #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int SEQ_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [DW-1:0]    tx_data,
    output logic             tx_ready,
    output logic             link_valid,
    output logic [DW-1:0]    link_data,
    output logic [SEQ_W-1:0] link_seq,
    input  logic             link_ready,
    input  logic             ack_valid,
    input  logic             ack_nak,
    input  logic [SEQ_W-1:0] ack_seq,
    output logic             ack_ready,
    output logic             ack_err,
    output logic             replay_rollover,
    output logic [AW-1:0]    ram_waddr,
    output logic [DW-1:0]    ram_din,
    output logic             ram_we,
    output logic [AW-1:0]    ram_raddr,
    output logic             ram_oe,
    input  logic [DW-1:0]    ram_dout,
    output logic [AW:0]      count
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, RP_ISSUE, RP_DATA} state_t;

    state_t           r_state, w_state_nxt;
    logic [AW-1:0]    r_head, r_tail, r_rp_ptr;
    logic [AW:0]      r_count, r_rp_left;
    logic [SEQ_W-1:0] r_oldest_seq, r_rp_seq;
    logic [1:0]       r_replay_num;
    logic             r_post_rst;

    logic             w_block, w_full, w_nak_req, w_idle_ok;
    logic             w_tx_ready, w_ack_ready, w_tx_acc, w_ack_acc;
    logic             w_n_ok, w_ack_do, w_nak_go;
    logic [SEQ_W-1:0] w_n, w_next_seq;
    logic [AW:0]      w_n_cnt, w_remain, w_sub, w_add;

    // Outputs stay quiet through the reset cycle and the one following it.
    assign w_block     = rst || r_post_rst;
    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_nak_req   = ack_valid && ack_nak;
    assign w_idle_ok   = (r_state == IDLE) && !w_block;
    assign w_tx_ready  = w_idle_ok && !w_full && link_ready && !w_nak_req;
    assign w_ack_ready = w_idle_ok;
    assign w_tx_acc    = tx_valid && w_tx_ready;
    assign w_ack_acc   = ack_valid && w_ack_ready;

    // n is taken mod 2^SEQ_W so a duplicate ACK (ack_seq = oldest-1) gives 0.
    assign w_n        = ack_seq - r_oldest_seq + SEQ_W'(1);
    assign w_n_ok     = (w_n <= SEQ_W'(r_count));
    assign w_n_cnt    = w_n[AW:0];
    assign w_remain   = r_count - w_n_cnt;
    assign w_ack_do   = w_ack_acc && w_n_ok;
    assign w_nak_go   = w_ack_do && ack_nak && (w_remain != '0);
    assign w_next_seq = r_oldest_seq + SEQ_W'(r_count);
    assign w_sub      = w_ack_do ? w_n_cnt : '0;
    assign w_add      = w_tx_acc ? (AW+1)'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_oldest_seq <= '0;
            r_replay_num <= '0;
            r_rp_ptr     <= '0;
            r_rp_seq     <= '0;
            r_rp_left    <= '0;
            r_post_rst   <= 1'b1;
        end else begin
            r_post_rst <= 1'b0;
            r_state    <= w_state_nxt;
            r_count    <= r_count - w_sub + w_add;
            if (w_tx_acc) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_ack_do) begin
                r_head       <= r_head + w_n_cnt[AW-1:0];
                r_oldest_seq <= r_oldest_seq + w_n;
                if (!ack_nak && (w_n != '0)) begin
                    r_replay_num <= '0;
                end
            end
            if (w_nak_go) begin
                r_rp_ptr     <= r_head + w_n_cnt[AW-1:0];
                r_rp_seq     <= r_oldest_seq + w_n;
                r_rp_left    <= w_remain;
                r_replay_num <= r_replay_num + 2'd1;
            end
            if ((r_state == RP_DATA) && link_ready) begin
                r_rp_ptr  <= r_rp_ptr + AW'(1);
                r_rp_seq  <= r_rp_seq + SEQ_W'(1);
                r_rp_left <= r_rp_left - (AW+1)'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        tx_ready        = w_tx_ready;
        ack_ready       = w_ack_ready;
        link_valid      = 1'b0;
        link_data       = '0;
        link_seq        = '0;
        ram_we          = 1'b0;
        ram_waddr       = '0;
        ram_din         = '0;
        ram_oe          = 1'b0;
        ram_raddr       = w_block ? '0 : r_head;
        ack_err         = w_ack_acc && !w_n_ok;
        replay_rollover = w_nak_go && (r_replay_num == 2'd3);
        count           = w_block ? '0 : r_count;
        if (!w_block) begin
            unique case (r_state)
                IDLE: begin
                    link_valid = tx_valid && !w_full && !w_nak_req;
                    link_data  = tx_data;
                    link_seq   = w_next_seq;
                    ram_we     = w_tx_acc;
                    ram_waddr  = r_tail;
                    ram_din    = tx_data;
                    if (w_nak_go) begin
                        w_state_nxt = RP_ISSUE;
                    end
                end
                RP_ISSUE: begin
                    ram_raddr   = r_rp_ptr;
                    ram_oe      = 1'b1;
                    w_state_nxt = RP_DATA;
                end
                RP_DATA: begin
                    ram_raddr  = r_rp_ptr;
                    ram_oe     = 1'b1;
                    link_valid = 1'b1;
                    link_data  = ram_dout;
                    link_seq   = r_rp_seq;
                    if (link_ready) begin
                        w_state_nxt = (r_rp_left == (AW+1)'(1)) ? IDLE : RP_ISSUE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_replay_ctrl.sv
// Directed bench for replay_ctrl with a behavioural 8x16 RAM (1-cycle read).
module tb_replay_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;
    logic        link_valid;
    logic [15:0] link_data;
    logic [11:0] link_seq;
    logic        link_ready;
    logic        ack_valid;
    logic        ack_nak;
    logic [11:0] ack_seq;
    logic        ack_ready;
    logic        ack_err;
    logic        replay_rollover;
    logic [2:0]  ram_waddr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [2:0]  ram_raddr;
    logic        ram_oe;
    logic [15:0] ram_dout;
    logic [3:0]  count;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [15:0] mem [8];
    logic [15:0] exp_d [$];
    logic [15:0] d;

    always #5 clk = ~clk;

    replay_ctrl #(.DW(16), .AW(3), .SEQ_W(12)) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .link_valid(link_valid), .link_data(link_data), .link_seq(link_seq),
        .link_ready(link_ready),
        .ack_valid(ack_valid), .ack_nak(ack_nak), .ack_seq(ack_seq), .ack_ready(ack_ready),
        .ack_err(ack_err), .replay_rollover(replay_rollover),
        .ram_waddr(ram_waddr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_raddr(ram_raddr), .ram_oe(ram_oe), .ram_dout(ram_dout),
        .count(count)
    );

    // RAM model: registered read, Z while writing.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_din;
            ram_dout       <= 'z;
        end else if (ram_oe) begin
            ram_dout <= mem[ram_raddr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic send(input logic [15:0] dat, input logic [11:0] s, input logic [2:0] a);
        tx_valid = 1'b1;
        tx_data  = dat;
        #1;
        check("tx_ready", 32'(tx_ready), 32'd1);
        check("fwd_valid", 32'(link_valid), 32'd1);
        check("fwd_data", 32'(link_data), 32'(dat));
        check("fwd_seq", 32'(link_seq), 32'(s));
        check("wr_en", 32'(ram_we), 32'd1);
        check("wr_addr", 32'(ram_waddr), 32'(a));
        check("wr_data", 32'(ram_din), 32'(dat));
        cyc();
        tx_valid = 1'b0;
        tx_data  = '0;
    endtask

    task automatic replay(input logic [11:0] s0, input logic [2:0] a0);
        logic [2:0]  a;
        logic [11:0] s;
        for (int k = 0; k < exp_d.size(); k++) begin
            a = a0 + 3'(k);
            s = s0 + 12'(k);
            #1;
            check("rp_iss_valid", 32'(link_valid), 32'd0);
            check("rp_iss_oe", 32'(ram_oe), 32'd1);
            check("rp_iss_we", 32'(ram_we), 32'd0);
            check("rp_iss_addr", 32'(ram_raddr), 32'(a));
            cyc();
            #1;
            check("rp_valid", 32'(link_valid), 32'd1);
            check("rp_seq", 32'(link_seq), 32'(s));
            check("rp_data", 32'(link_data), 32'(exp_d[k]));
            check("rp_we", 32'(ram_we), 32'd0);
            check("rp_addr", 32'(ram_raddr), 32'(a));
            cyc();
        end
        #1;
        check("rp_end_valid", 32'(link_valid), 32'd0);
        check("rp_end_oe", 32'(ram_oe), 32'd0);
        check("rp_end_ackrdy", 32'(ack_ready), 32'd1);
    endtask

    task automatic ack(input logic nak, input logic [11:0] s);
        ack_valid = 1'b1;
        ack_nak   = nak;
        ack_seq   = s;
    endtask

    initial begin
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; link_ready = 1'b1;
        ack_valid = 1'b0; ack_nak = 1'b0; ack_seq = '0;

        // Reset cycle and the cycle after: outputs quiet even with requests pending.
        cyc();
        cyc();
        tx_valid = 1'b1; tx_data = 16'h1234; ack(1'b0, 12'h000);
        #1;
        check("rst_link_valid", 32'(link_valid), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_ack_ready", 32'(ack_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_raddr", 32'(ram_raddr), 32'd0);
        rst = 1'b0;
        #1;
        check("post_link_valid", 32'(link_valid), 32'd0);
        check("post_ram_we", 32'(ram_we), 32'd0);
        check("post_ack_ready", 32'(ack_ready), 32'd0);
        cyc();
        tx_valid = 1'b0; ack_valid = 1'b0;
        #1;
        check("idle_ack_ready", 32'(ack_ready), 32'd1);
        check("idle_tx_ready", 32'(tx_ready), 32'd1);
        check("idle_count", 32'(count), 32'd0);

        // Basic forward path, then fill and ACK.
        for (int i = 0; i < 3; i++) send(16'h0A01 + 16'(i), 12'(i), 3'(i));
        #1;
        check("count3", 32'(count), 32'd3);
        for (int i = 3; i < 8; i++) send(16'h0A01 + 16'(i), 12'(i), 3'(i));
        tx_valid = 1'b1; tx_data = 16'h0A09;
        #1;
        check("full_tx_ready", 32'(tx_ready), 32'd0);
        check("full_link_valid", 32'(link_valid), 32'd0);
        check("full_ram_we", 32'(ram_we), 32'd0);
        check("full_count", 32'(count), 32'd8);
        tx_valid = 1'b0;
        ack(1'b0, 12'd3);
        #1;
        check("full_ack_ready", 32'(ack_ready), 32'd1);
        check("full_ack_err", 32'(ack_err), 32'd0);
        cyc();
        ack_valid = 1'b0;
        #1;
        check("ack3_count", 32'(count), 32'd4);
        check("ack3_head", 32'(ram_raddr), 32'd4);
        check("ack3_tx_ready", 32'(tx_ready), 32'd1);

        // NAK with partial purge, then replay.
        do_reset();
        for (int i = 0; i < 5; i++) send(16'h0B00 + 16'(i), 12'(i), 3'(i));
        ack(1'b1, 12'd1);
        #1;
        check("nak_err", 32'(ack_err), 32'd0);
        check("nak_tx_ready", 32'(tx_ready), 32'd0);
        check("nak_rollover", 32'(replay_rollover), 32'd0);
        cyc();
        ack_valid = 1'b0;
        exp_d = '{16'h0B02, 16'h0B03, 16'h0B04};
        #1;
        check("rp_ack_ready", 32'(ack_ready), 32'd0);
        check("rp_count", 32'(count), 32'd3);
        replay(12'd2, 3'd2);
        check("after_rp_count", 32'(count), 32'd3);

        // Same replay with link_ready stalled on the first entry.
        ack(1'b1, 12'd1);
        cyc();
        ack_valid = 1'b0;
        cyc();
        link_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_valid", 32'(link_valid), 32'd1);
            check("stall_data", 32'(link_data), 32'h0B02);
            check("stall_seq", 32'(link_seq), 32'd2);
            cyc();
        end
        link_ready = 1'b1;
        #1;
        check("unstall_data", 32'(link_data), 32'h0B02);
        cyc();
        exp_d = '{16'h0B03, 16'h0B04};
        replay(12'd3, 3'd3);
        check("stall_count", 32'(count), 32'd3);

        // Range check on ACK.
        do_reset();
        for (int i = 0; i < 3; i++) send(16'h0D00 + 16'(i), 12'(i), 3'(i));
        ack(1'b0, 12'd4090);
        #1;
        check("oor_err", 32'(ack_err), 32'd1);
        cyc();
        ack_valid = 1'b0;
        #1;
        check("oor_err_clear", 32'(ack_err), 32'd0);
        check("oor_count", 32'(count), 32'd3);
        check("oor_head", 32'(ram_raddr), 32'd0);
        ack(1'b0, 12'd4095);
        #1;
        check("dup_err", 32'(ack_err), 32'd0);
        cyc();
        ack(1'b0, 12'd3);
        #1;
        check("n_cnt1_err", 32'(ack_err), 32'd1);
        cyc();
        ack_valid = 1'b0;
        tx_valid = 1'b1; link_ready = 1'b0;
        #1;
        check("dup_count", 32'(count), 32'd3);
        check("next_seq", 32'(link_seq), 32'd3);
        check("noready_tx_ready", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0; link_ready = 1'b1;
        ack(1'b0, 12'd2);
        #1;
        check("ack_all_err", 32'(ack_err), 32'd0);
        cyc();
        ack_valid = 1'b0;
        #1;
        check("ack_all_count", 32'(count), 32'd0);
        check("ack_all_head", 32'(ram_raddr), 32'd3);

        // Long stream with ACK every 4 words concurrent with a send.
        do_reset();
        for (int i = 0; i < 4100; i++) begin
            d = 16'(i) ^ 16'h5A5A;
            tx_valid = 1'b1; tx_data = d;
            if (i > 0 && (i % 4) == 0) ack(1'b0, 12'(i - 1));
            else ack_valid = 1'b0;
            #1;
            check("str_seq", 32'(link_seq), 32'(i % 4096));
            check("str_addr", 32'(ram_waddr), 32'(i % 8));
            check("str_din", 32'(ram_din), 32'(d));
            check("str_rdy", 32'(tx_ready), 32'd1);
            if (ack_valid) check("str_err", 32'(ack_err), 32'd0);
            cyc();
        end
        tx_valid = 1'b0; ack_valid = 1'b0;
        #1;
        check("str_count", 32'(count), 32'd4);
        check("str_head", 32'(ram_raddr), 32'd0);
        ack(1'b1, 12'hFFF);
        cyc();
        ack_valid = 1'b0;
        exp_d = {};
        for (int k = 0; k < 4; k++) exp_d.push_back(16'(4096 + k) ^ 16'h5A5A);
        replay(12'd0, 3'd0);

        // Four NAKs without progress; the fourth raises rollover.
        do_reset();
        send(16'h0C00, 12'd0, 3'd0);
        send(16'h0C01, 12'd1, 3'd1);
        exp_d = '{16'h0C00, 16'h0C01};
        for (int r = 0; r < 4; r++) begin
            ack(1'b1, 12'hFFF);
            #1;
            check("rollover", 32'(replay_rollover), (r == 3) ? 32'd1 : 32'd0);
            cyc();
            ack_valid = 1'b0;
            replay(12'd0, 3'd0);
        end

        // Reset in the middle of a replay.
        ack(1'b1, 12'hFFF);
        cyc();
        ack_valid = 1'b0;
        cyc();
        #1;
        check("mid_valid", 32'(link_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(link_valid), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        check("mid_post_valid", 32'(link_valid), 32'd0);
        check("mid_post_oe", 32'(ram_oe), 32'd0);
        check("mid_post_count", 32'(count), 32'd0);
        cyc();
        #1;
        check("mid_idle_ack_ready", 32'(ack_ready), 32'd1);
        check("mid_idle_oe", 32'(ram_oe), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/replay_ctrl.md
# replay_ctrl

Replay-buffer controller for the transmit side of the link layer. It sits directly upstream of the 8×16 `ram` block. It assigns sequence numbers to outgoing words and forwards them to the link while writing a copy into the RAM. It purges entries on ACK and, on NAK, re-reads and retransmits all unacknowledged entries from the RAM in order.

## Interface
- `DW`, 16: data width; matches the RAM word.
- `AW`, 3: RAM address width. `DEPTH` = 2^AW = 8 entries.
- `SEQ_W`, 12: sequence-number width. All sequence arithmetic is mod 2^SEQ_W.

Ports:
- `clk` in 1: single clock. Everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tx_valid` in 1, `tx_data` in DW, `tx_ready` out 1: new-word input. A word is accepted when `tx_valid && tx_ready`.
- `link_valid` out 1, `link_data` out DW, `link_seq` out SEQ_W, `link_ready` in 1: link output.
- `ack_valid` in 1, `ack_nak` in 1 (1 = NAK), `ack_seq` in SEQ_W, `ack_ready` out 1: ACK/NAK input.
- `ack_err` out 1: one-cycle pulse when an ACK/NAK is out of range.
- `replay_rollover` out 1: one-cycle pulse on the 4th consecutive replay without forward progress.
- `ram_waddr` out AW, `ram_din` out DW, `ram_we` out 1: RAM write port.
- `ram_raddr` out AW, `ram_oe` out 1, `ram_dout` in DW: RAM read port.
- `count` out AW+1: number of unacknowledged entries, 0..DEPTH.

## Operation
Tracked state:
- `head`: address of the oldest entry.
- `tail`: next write address.
- `count`.
- `oldest_seq`: sequence number stored at `head`.
- `next_seq` = `oldest_seq + count`.
- `replay_num`: 2 bits.
- FSM state.

`head` and `tail` wrap DEPTH-1 → 0.

FSM states: IDLE, RP_ISSUE, RP_DATA.

IDLE:
- `tx_ready` = `!rst && count<DEPTH && link_ready && !(ack_valid && ack_nak)`.
- `link_valid` = `tx_valid && count<DEPTH && !(ack_valid && ack_nak)`.
- `link_data` = `tx_data` and `link_seq` = `next_seq` (combinational pass-through).
- On accept: `ram_we`=1, `ram_waddr`=`tail`, `ram_din`=`tx_data`; then `tail`++ and `count`++.
- `ack_ready` = 1 in IDLE only. It is 0 in the RP_* states, so ACK/NAKs are held off during replay.

ACK/NAK handling (accepted `ack_valid`):
- Compute n = (`ack_seq` − `oldest_seq` + 1) mod 2^SEQ_W.
- If n > `count`: no state change and `ack_err` pulses.
- Otherwise: `head` += n, `oldest_seq` += n, `count` −= n. n = 0 is legal (a duplicate ACK).
- ACK with n ≥ 1: `replay_num` is cleared.
- NAK, after the purge:
  - If the remaining count > 0: snapshot `rp_ptr`=new `head`, `rp_seq`=new `oldest_seq`, `rp_left`=remaining count, then go to RP_ISSUE.
  - If `replay_num`==3: pulse `replay_rollover`.
  - `replay_num` increments, wrapping 3 → 0.
  - If the remaining count is 0: stay in IDLE and leave `replay_num` unchanged.
- A simultaneous tx accept and ACK in the same cycle is legal: `count` ← `count` − n + 1. n is evaluated against the pre-cycle state.

RP_ISSUE:
- `ram_raddr`=`rp_ptr`, `ram_oe`=1, `ram_we`=0, `link_valid`=0.
- Next state is RP_DATA.

RP_DATA:
- `ram_raddr` is held at `rp_ptr`, `ram_oe`=1, `ram_we`=0.
- `link_valid`=1, `link_data`=`ram_dout`, `link_seq`=`rp_seq`.
- On `link_ready`: `rp_ptr`++, `rp_seq`++, `rp_left`−−.
  - If `rp_left` was 1: go to IDLE.
  - Otherwise: go to RP_ISSUE.

`ram_we` is never 1 in any cycle where `ram_dout` is sampled. The RAM drives Z when `we` is high.

Outside the RP_* states, `ram_oe`=0 and `ram_raddr`=`head`.

## Timing
- Reset values: state IDLE; `head`, `tail`, `count`, `oldest_seq`, `replay_num` = 0. All outputs are 0 during the reset cycle and in the cycle after it, except `ram_raddr`=0.
- The forward path has 0-cycle latency from `tx_data` to `link_data`. The RAM write commits on the same edge as the accept.
- Replay: the first `link_valid` appears 2 cycles after the NAK edge (NAK edge → RP_ISSUE → RP_DATA). Each entry takes a minimum of 2 cycles.
- RAM read latency is 1 cycle. `ram_dout` stays stable in RP_DATA while `ram_raddr` is held, which covers `link_ready` stalls.
- Reset in any state, including mid-replay: on the next edge everything is in reset state, `ram_oe`=0, and no further `link_valid`.
- Full (`count`==DEPTH): `tx_ready`=0. ACK/NAK processing is still accepted.
- Sequence numbers wrap 2^SEQ_W−1 → 0. The range check uses mod arithmetic.

## Test plan
- Reset, then send 0x0A01, 0x0A02, 0x0A03 → `link_seq` 0,1,2; RAM writes at addresses 0,1,2; `count`=3.
- Fill to 8 entries → `tx_ready`=0. Then ACK seq 3 → `count`=4, `head`=4, `tx_ready`=1 next cycle.
- 5 outstanding (seq 0..4, data 0x0B00..0x0B04), NAK seq 1 → purge 2. Replay outputs (seq 2, 0x0B02), (seq 3, 0x0B03), (seq 4, 0x0B04), each ≥2 cycles apart, `ram_we`=0 throughout, then IDLE with `count`=3. Repeat with `link_ready` stalled 3 cycles → data held.
- `oldest_seq`=0, `count`=3, ACK seq 4090 → `ack_err` pulse, state unchanged. ACK seq 4095 (n=0) → no change, no error.
- Stream 4100 words with an ACK every 4 → `link_seq` wraps 4095 → 0; `head`/`tail` wrap 7 → 0; data intact.
- Four NAK seq 0xFFF with 2 outstanding → 4 replays, `replay_rollover` pulses with the 4th. Assert `rst` during RP_DATA → `link_valid`, `ram_oe`, `count` are 0 next cycle.
